// File: rtl/setpoint_ctrl.sv
// setpoint_ctrl: holds one committed setpoint per channel and runs a single
// edit session (step up/down with saturation, hold-to-repeat, confirm,
// cancel on mode exit or inactivity timeout) while the mode FSM is in the
// setpoint-edit state.
//
// Pulse semantics: commit and cancel are single-cycle strobes that are
// mutually exclusive. set_val is already updated in the cycle commit is high.
// The FSM state is visible on the editing output (high exactly in EDIT).
module setpoint_ctrl #(
    parameter int          WIDTH        = 8,
    parameter int          NUM_CH       = 2,
    parameter int          CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int          STEP         = 1,
    parameter int          MIN_VAL      = 0,
    parameter int          MAX_VAL      = (1 << WIDTH) - 1,
    parameter int          INIT_VAL     = 24,
    parameter logic [1:0]  EDIT_CODE    = 2'b11,
    parameter int          REPEAT_DELAY = 50_000_000,
    parameter int          REPEAT_RATE  = 10_000_000,
    parameter int          TIMEOUT      = 500_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4:0]                rise_button,
    input  logic [4:0]                hold_button,
    input  logic [1:0]                mode_state,
    input  logic [CH_W-1:0]           ch_sel,
    input  logic [NUM_CH*WIDTH-1:0]   cur_value,
    output logic [NUM_CH*WIDTH-1:0]   set_val,
    output logic [WIDTH-1:0]          work_val,
    output logic [CH_W-1:0]           edit_ch,
    output logic                      editing,
    output logic                      commit,
    output logic                      cancel
);

    // Bounds and step widened by one bit so step arithmetic never wraps.
    localparam logic [WIDTH:0] MIN_X  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VAL);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EDIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_set [NUM_CH];
    logic [WIDTH-1:0]  r_work;
    logic [CH_W-1:0]   r_edit_ch;
    logic              r_commit;
    logic              r_cancel;
    logic              r_prev_edit;
    logic              r_rep_run;
    logic [31:0]       r_rep_cnt;
    logic [31:0]       r_to_cnt;

    logic [WIDTH-1:0]  w_cur [NUM_CH];
    logic              w_mode_edit;
    logic              w_entry;
    logic [CH_W-1:0]   w_sel_ch;
    logic [WIDTH-1:0]  w_entry_raw;
    logic [WIDTH-1:0]  w_entry_val;
    logic [WIDTH:0]    w_up_sum;
    logic [WIDTH:0]    w_dn_diff;
    logic [WIDTH-1:0]  w_up_val;
    logic [WIDTH-1:0]  w_dn_val;
    logic              w_hold_one;
    logic [31:0]       w_rep_lim;
    logic              w_rep_fire;
    logic              w_any_step_rise;
    logic              w_do_up;
    logic              w_do_dn;
    logic              w_activity;
    logic              w_timeout;
    logic              w_unused_bits;

    // Unpack live values and pack committed setpoints.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign w_cur[g]                   = cur_value[g*WIDTH +: WIDTH];
        assign set_val[g*WIDTH +: WIDTH]  = r_set[g];
    end

    assign w_unused_bits = ^{rise_button[3], rise_button[1], hold_button[3:1]};

    // Session entry detection, channel mapping and entry clamp.
    always_comb begin
        w_mode_edit = (mode_state == EDIT_CODE);
        w_entry     = w_mode_edit && !r_prev_edit;
        w_sel_ch    = (32'(ch_sel) < NUM_CH) ? ch_sel : '0;
        w_entry_raw = w_cur[w_sel_ch];
        if ({1'b0, w_entry_raw} < MIN_X)
            w_entry_val = MIN_X[WIDTH-1:0];
        else if ({1'b0, w_entry_raw} > MAX_X)
            w_entry_val = MAX_X[WIDTH-1:0];
        else
            w_entry_val = w_entry_raw;
    end

    // Saturating step results, computed one bit wider than the value.
    always_comb begin
        w_up_sum  = {1'b0, r_work} + STEP_X;
        w_dn_diff = {1'b0, r_work} - STEP_X;
        w_up_val  = (w_up_sum > MAX_X) ? MAX_X[WIDTH-1:0] : w_up_sum[WIDTH-1:0];
        w_dn_val  = (({1'b0, r_work} < STEP_X) || (w_dn_diff < MIN_X))
                    ? MIN_X[WIDTH-1:0] : w_dn_diff[WIDTH-1:0];
    end

    // Step source selection: edge pulses win over auto-repeat; up+down cancels.
    always_comb begin
        w_hold_one      = hold_button[0] ^ hold_button[4];
        w_rep_lim       = r_rep_run ? 32'(REPEAT_RATE - 1) : 32'(REPEAT_DELAY - 1);
        w_rep_fire      = w_hold_one && (r_rep_cnt == w_rep_lim);
        w_any_step_rise = rise_button[0] | rise_button[4];
        if (w_any_step_rise) begin
            w_do_up = rise_button[0] & ~rise_button[4];
            w_do_dn = rise_button[4] & ~rise_button[0];
        end else begin
            w_do_up = w_rep_fire & hold_button[0];
            w_do_dn = w_rep_fire & hold_button[4];
        end
        w_activity = rise_button[0] | rise_button[2] | rise_button[4] | w_rep_fire;
        w_timeout  = !w_activity && (r_to_cnt == 32'(TIMEOUT - 1));
    end

    // Session FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            for (int c = 0; c < NUM_CH; c++) r_set[c] <= INIT_W;
            r_work      <= INIT_W;
            r_edit_ch   <= '0;
            r_commit    <= 1'b0;
            r_cancel    <= 1'b0;
            r_prev_edit <= 1'b0;
            r_rep_run   <= 1'b0;
            r_rep_cnt   <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_commit    <= 1'b0;
            r_cancel    <= 1'b0;
            r_prev_edit <= w_mode_edit;
            case (r_state)
                S_IDLE: begin
                    if (w_entry) begin
                        r_state   <= S_EDIT;
                        r_edit_ch <= w_sel_ch;
                        r_work    <= w_entry_val;
                        r_rep_run <= 1'b0;
                        r_rep_cnt <= '0;
                        r_to_cnt  <= '0;
                    end
                end
                S_EDIT: begin
                    if (rise_button[2]) begin
                        // Commit the pre-step value even if a step arrives together.
                        r_set[r_edit_ch] <= r_work;
                        r_commit         <= 1'b1;
                        r_state          <= S_IDLE;
                    end else if (!w_mode_edit || w_timeout) begin
                        r_work   <= r_set[r_edit_ch];
                        r_cancel <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        if (w_do_up)
                            r_work <= w_up_val;
                        else if (w_do_dn)
                            r_work <= w_dn_val;

                        if (!w_hold_one) begin
                            r_rep_cnt <= '0;
                            r_rep_run <= 1'b0;
                        end else if (w_rep_fire) begin
                            r_rep_cnt <= '0;
                            r_rep_run <= 1'b1;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 32'd1;
                        end

                        r_to_cnt <= w_activity ? '0 : r_to_cnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign work_val = r_work;
    assign edit_ch  = r_edit_ch;
    assign editing  = (r_state == S_EDIT);
    assign commit   = r_commit;
    assign cancel   = r_cancel;

endmodule

// File: tb/tb_setpoint_ctrl.sv
// Bench for setpoint_ctrl: directed sessions; commit/cancel events are checked
// by a monitor against an expected queue, working values checked in-line.
module tb_setpoint_ctrl;

  localparam int W  = 8;
  localparam int NC = 2;
  localparam int EW = 2 + NC * W;

  logic            clk;
  logic            rst_n;
  logic [4:0]      rise_button;
  logic [4:0]      hold_button;
  logic [1:0]      mode_state;
  logic [0:0]      ch_sel;
  logic [NC*W-1:0] cur_value;
  logic [NC*W-1:0] set_val;
  logic [W-1:0]    work_val;
  logic [0:0]      edit_ch;
  logic            editing;
  logic            commit;
  logic            cancel;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  setpoint_ctrl #(
    .WIDTH(8), .NUM_CH(2), .STEP(1), .MIN_VAL(10), .MAX_VAL(40),
    .INIT_VAL(24), .EDIT_CODE(2'b11), .REPEAT_DELAY(4), .REPEAT_RATE(2),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(rst_n), .rise_button(rise_button), .hold_button(hold_button),
    .mode_state(mode_state), .ch_sel(ch_sel), .cur_value(cur_value),
    .set_val(set_val), .work_val(work_val), .edit_ch(edit_ch), .editing(editing),
    .commit(commit), .cancel(cancel)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] b);
    rise_button = b;
    tick();
    rise_button = '0;
  endtask

  task automatic enter(input int ch, input logic [7:0] v);
    mode_state = 2'b00;
    tick();
    cur_value[ch*8 +: 8] = v;
    ch_sel = ch[0:0];
    mode_state = 2'b11;
    tick();
  endtask

  task automatic expect_event(input logic c, input logic x, input logic [7:0] s1, input logic [7:0] s0);
    exp_q.push_back({c, x, s1, s0});
  endtask

  // monitor: every commit/cancel strobe must match the next expected event
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && (commit || cancel)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event actual c=%0b x=%0b set=%h required none",
                   commit, cancel, set_val);
        end else begin
          e = exp_q.pop_front();
          if ({commit, cancel, set_val} !== e) begin
            errors++;
            $display("FAIL event actual c=%0b x=%0b set=%h required c=%0b x=%0b set=%h",
                     commit, cancel, set_val, e[EW-1], e[EW-2], e[NC*W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rise_button = '0;
    hold_button = '0;
    mode_state = 2'b00;
    ch_sel = '0;
    cur_value = {8'd30, 8'd50};
    tick();
    tick();
    // reset state
    check("rst_set_val", 32'(set_val), {16'd0, 8'd24, 8'd24});
    check("rst_work", 32'(work_val), 32'd24);
    check("rst_edit_ch", 32'(edit_ch), 32'd0);
    check("rst_flags", {29'd0, editing, commit, cancel}, 32'd0);
    rst_n = 1'b1;
    tick();

    // basic edit on channel 1: 30 -> 33, commit
    enter(1, 8'd30);
    check("t1_editing", 32'(editing), 32'd1);
    check("t1_work_entry", 32'(work_val), 32'd30);
    check("t1_edit_ch", 32'(edit_ch), 32'd1);
    pulse(5'b00001);
    check("t1_up1", 32'(work_val), 32'd31);
    pulse(5'b00001);
    pulse(5'b00001);
    check("t1_up3", 32'(work_val), 32'd33);
    expect_event(1'b1, 1'b0, 8'd33, 8'd24);
    pulse(5'b00100);
    check("t1_idle", 32'(editing), 32'd0);
    check("t1_work_after", 32'(work_val), 32'd33);
    tick();
    tick();
    check("t1_no_reentry", 32'(editing), 32'd0);

    // saturation at MAX_VAL (40)
    enter(0, 8'd39);
    check("t2_entry", 32'(work_val), 32'd39);
    pulse(5'b00001);
    check("t2_up_to_max", 32'(work_val), 32'd40);
    pulse(5'b00001);
    check("t2_stay_max", 32'(work_val), 32'd40);
    expect_event(1'b1, 1'b0, 8'd33, 8'd40);
    pulse(5'b00100);

    // entry clamp at MIN_VAL (10), saturation at MIN, cancel on mode exit
    enter(0, 8'd5);
    check("t3_entry_clamp_min", 32'(work_val), 32'd10);
    pulse(5'b10000);
    check("t3_stay_min", 32'(work_val), 32'd10);
    pulse(5'b00001);
    check("t3_up", 32'(work_val), 32'd11);
    pulse(5'b10000);
    check("t3_down_to_min", 32'(work_val), 32'd10);
    expect_event(1'b0, 1'b1, 8'd33, 8'd40);
    mode_state = 2'b00;
    tick();
    check("t3_cancel_idle", 32'(editing), 32'd0);
    check("t3_work_restored", 32'(work_val), 32'd40);

    // auto-repeat: delay 4, rate 2, ten held cycles from 20
    enter(1, 8'd20);
    hold_button = 5'b00001;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) check("t4_rep_c3", 32'(work_val), 32'd20);
      if (i == 4) check("t4_rep_c4", 32'(work_val), 32'd21);
      if (i == 5) check("t4_rep_c5", 32'(work_val), 32'd21);
      if (i == 6) check("t4_rep_c6", 32'(work_val), 32'd22);
    end
    check("t4_rep_final", 32'(work_val), 32'd24);
    hold_button = 5'b10001;
    repeat (5) tick();
    check("t4_both_held", 32'(work_val), 32'd24);
    hold_button = '0;
    expect_event(1'b1, 1'b0, 8'd24, 8'd40);
    pulse(5'b00100);

    // inactivity timeout of 8 cycles
    enter(0, 8'd27);
    check("t5_entry", 32'(work_val), 32'd27);
    repeat (7) tick();
    check("t5_before_timeout", 32'(editing), 32'd1);
    expect_event(1'b0, 1'b1, 8'd24, 8'd40);
    tick();
    check("t5_after_timeout", 32'(editing), 32'd0);
    check("t5_work_restored", 32'(work_val), 32'd40);

    // up+down together: no change; confirm+up: pre-step committed
    enter(1, 8'd30);
    pulse(5'b10001);
    check("t6_up_down", 32'(work_val), 32'd30);
    expect_event(1'b1, 1'b0, 8'd30, 8'd40);
    pulse(5'b00101);
    check("t6_confirm_up_work", 32'(work_val), 32'd30);

    // entry clamp at MAX, then reset mid-session
    enter(0, 8'd255);
    check("t7_entry_clamp_max", 32'(work_val), 32'd40);
    pulse(5'b10000);
    check("t7_down", 32'(work_val), 32'd39);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_set_val", 32'(set_val), {16'd0, 8'd24, 8'd24});
    check("t7_rst_work", 32'(work_val), 32'd24);
    check("t7_rst_flags", {29'd0, editing, commit, cancel}, 32'd0);
    mode_state = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_after_rst_idle", 32'(editing), 32'd0);

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
